// File: rtl/acc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : acc_sequencer                                          |
// | Description : Fetch/decode/execute control unit of the accumulator   |
// |               core: memory req/ack sequencing, ALU drive, acc/pc/ir. |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module acc_sequencer #(
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            mem_req,
    output logic            mem_we,
    output logic [BITS-6:0] mem_addr,
    output logic [BITS-1:0] mem_wdata,
    input  logic [BITS-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic [BITS-1:0] alu_a,
    output logic [BITS-1:0] alu_acc_in,
    output logic [4:0]      alu_opcode,
    input  logic [BITS-1:0] alu_acc_out,
    output logic [BITS-1:0] acc,
    output logic [BITS-6:0] pc,
    output logic            busy,
    output logic            halted
);

    localparam int c_ADDR_W = BITS - 5;

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_FETCH = 3'd1;
    localparam logic [2:0] c_S_OPRD  = 3'd2;
    localparam logic [2:0] c_S_EXEC  = 3'd3;
    localparam logic [2:0] c_S_STORE = 3'd4;
    localparam logic [2:0] c_S_HALT  = 3'd5;

    localparam logic [4:0] c_OP_NOP   = 5'b00000;
    localparam logic [4:0] c_OP_HALT  = 5'b00001;
    localparam logic [4:0] c_OP_STORE = 5'b01000;
    localparam logic [4:0] c_OP_JMP   = 5'b01001;
    localparam logic [4:0] c_OP_JZ    = 5'b01010;

    function automatic logic f_is_direct(input logic [4:0] op);
        case (op)
            5'b00010, 5'b00100, 5'b00110,
            5'b10000, 5'b10010, 5'b10100: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic f_is_imm(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00101, 5'b00111, 5'b10001, 5'b10011,
            5'b10101, 5'b10110, 5'b10111, 5'b11001, 5'b01111: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    logic [2:0]          r_state;
    logic [c_ADDR_W-1:0] r_pc;
    logic [BITS-1:0]     r_acc;
    logic [BITS-1:0]     r_ir;
    logic [BITS-1:0]     r_opnd;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [c_ADDR_W-1:0] r_mem_addr;
    logic [4:0]          r_alu_opcode;
    logic                r_busy;
    logic                r_halted;

    logic [2:0]          w_state_nx;
    logic [c_ADDR_W-1:0] w_pc_nx;
    logic [BITS-1:0]     w_acc_nx;
    logic [BITS-1:0]     w_ir_nx;
    logic [BITS-1:0]     w_opnd_nx;
    logic [c_ADDR_W-1:0] w_pc_inc;
    logic [4:0]          w_fetch_op;
    logic [c_ADDR_W-1:0] w_fetch_field;
    logic [4:0]          w_ir_op;
    logic [c_ADDR_W-1:0] w_ir_field;
    logic [4:0]          w_nx_op;
    logic [c_ADDR_W-1:0] w_nx_field;
    logic                w_nx_req;

    assign w_pc_inc      = r_pc + c_ADDR_W'(1);
    assign w_fetch_op    = mem_rdata[BITS-1 -: 5];
    assign w_fetch_field = mem_rdata[c_ADDR_W-1:0];
    assign w_ir_op       = r_ir[BITS-1 -: 5];
    assign w_ir_field    = r_ir[c_ADDR_W-1:0];

    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_acc_nx   = r_acc;
        w_ir_nx    = r_ir;
        w_opnd_nx  = r_opnd;
        case (r_state)
            c_S_IDLE, c_S_HALT: begin
                if (start) begin
                    w_pc_nx    = '0;
                    w_acc_nx   = '0;
                    w_state_nx = c_S_FETCH;
                end
            end
            c_S_FETCH: begin
                if (mem_ack) begin
                    w_ir_nx = mem_rdata;
                    if (f_is_direct(w_fetch_op)) begin
                        w_state_nx = c_S_OPRD;
                    end else if (f_is_imm(w_fetch_op)) begin
                        w_opnd_nx  = {5'b00000, w_fetch_field};
                        w_state_nx = c_S_EXEC;
                    end else if (w_fetch_op == c_OP_STORE) begin
                        w_state_nx = c_S_STORE;
                    end else if (w_fetch_op == c_OP_HALT) begin
                        w_state_nx = c_S_HALT;
                    end else begin
                        w_state_nx = c_S_EXEC;
                    end
                end
            end
            c_S_OPRD: begin
                if (mem_ack) begin
                    w_opnd_nx  = mem_rdata;
                    w_state_nx = c_S_EXEC;
                end
            end
            c_S_EXEC: begin
                w_state_nx = c_S_FETCH;
                w_pc_nx    = w_pc_inc;
                if (f_is_direct(w_ir_op) || f_is_imm(w_ir_op)) begin
                    w_acc_nx = alu_acc_out;
                end else if (w_ir_op == c_OP_JMP) begin
                    w_pc_nx = w_ir_field;
                end else if (w_ir_op == c_OP_JZ && r_acc == '0) begin
                    w_pc_nx = w_ir_field;
                end
            end
            c_S_STORE: begin
                if (mem_ack) begin
                    w_pc_nx    = w_pc_inc;
                    w_state_nx = c_S_FETCH;
                end
            end
            default: w_state_nx = c_S_IDLE;
        endcase
    end

    // Bus and ALU outputs are registered from the next-state view so each
    // request is asserted in the very cycle its state is entered.
    assign w_nx_op    = w_ir_nx[BITS-1 -: 5];
    assign w_nx_field = w_ir_nx[c_ADDR_W-1:0];
    assign w_nx_req   = (w_state_nx == c_S_FETCH) || (w_state_nx == c_S_OPRD) ||
                        (w_state_nx == c_S_STORE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_S_IDLE;
            r_pc         <= '0;
            r_acc        <= '0;
            r_ir         <= '0;
            r_opnd       <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_alu_opcode <= c_OP_NOP;
            r_busy       <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_pc         <= w_pc_nx;
            r_acc        <= w_acc_nx;
            r_ir         <= w_ir_nx;
            r_opnd       <= w_opnd_nx;
            r_mem_req    <= w_nx_req;
            r_mem_we     <= (w_state_nx == c_S_STORE);
            r_mem_addr   <= (w_state_nx == c_S_FETCH) ? w_pc_nx :
                            w_nx_req                  ? w_nx_field : '0;
            r_alu_opcode <= (w_state_nx == c_S_EXEC) ? w_nx_op : c_OP_NOP;
            r_busy       <= w_nx_req || (w_state_nx == c_S_EXEC);
            r_halted     <= (w_state_nx == c_S_HALT);
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_acc;
    assign alu_a      = r_opnd;
    assign alu_acc_in = r_acc;
    assign alu_opcode = r_alu_opcode;
    assign acc        = r_acc;
    assign pc         = r_pc;
    assign busy       = r_busy;
    assign halted     = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_acc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_acc_sequencer                                       |
// | Description : Directed bench for acc_sequencer with memory and ALU   |
// |               models and a configurable ack delay.                   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_acc_sequencer;

    localparam logic [4:0] c_LD    = 5'b00010;
    localparam logic [4:0] c_LDI   = 5'b00011;
    localparam logic [4:0] c_ADDI  = 5'b00101;
    localparam logic [4:0] c_ANDI  = 5'b10001;
    localparam logic [4:0] c_NOT   = 5'b01111;
    localparam logic [4:0] c_SHLI  = 5'b10110;
    localparam logic [4:0] c_SHRI  = 5'b10111;
    localparam logic [4:0] c_STORE = 5'b01000;
    localparam logic [4:0] c_HALT  = 5'b00001;
    localparam logic [4:0] c_JMP   = 5'b01001;
    localparam logic [4:0] c_JZ    = 5'b01010;
    localparam logic [4:0] c_NOP   = 5'b00000;
    localparam logic [4:0] c_BAD   = 5'b11111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mem_req, mem_we, mem_ack;
    logic [10:0] mem_addr, pc;
    logic [15:0] mem_wdata, mem_rdata, alu_a, alu_acc_in, alu_acc_out, acc;
    logic [4:0]  alu_opcode;
    logic        busy, halted;

    logic [15:0] mem [0:2047];
    int          ack_wait;
    int          wait_cnt;
    int          errors = 0;
    int          checks = 0;

    logic [10:0] rd_log [0:1023];
    int          rd_n = 0;
    int          st_n = 0;
    logic [10:0] st_addr;
    logic [15:0] st_data;
    int          stab_err = 0;
    logic        pend = 1'b0;
    logic        p_we;
    logic [10:0] p_addr;
    logic [15:0] p_wd;

    acc_sequencer #(.BITS(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .alu_a      (alu_a),
        .alu_acc_in (alu_acc_in),
        .alu_opcode (alu_opcode),
        .alu_acc_out(alu_acc_out),
        .acc        (acc),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_req && (wait_cnt >= ack_wait);

    always @(posedge clk) begin
        wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
    end

    // ALU stand-in; JMP/JZ/unknown codes return garbage so a wrong acc load shows
    always_comb begin
        case (alu_opcode)
            5'b00010, 5'b00011: alu_acc_out = alu_a;
            5'b00100, 5'b00101: alu_acc_out = alu_acc_in + alu_a;
            5'b00110, 5'b00111: alu_acc_out = alu_acc_in - alu_a;
            5'b10000, 5'b10001: alu_acc_out = alu_acc_in & alu_a;
            5'b10010, 5'b10011: alu_acc_out = alu_acc_in | alu_a;
            5'b10100, 5'b10101: alu_acc_out = alu_acc_in ^ alu_a;
            5'b10110:           alu_acc_out = alu_acc_in << alu_a[3:0];
            5'b10111:           alu_acc_out = alu_acc_in >> alu_a[3:0];
            5'b01111, 5'b11111: alu_acc_out = ~alu_acc_in;
            5'b01001, 5'b01010: alu_acc_out = alu_acc_in ^ 16'hA5A5;
            default:            alu_acc_out = alu_acc_in;
        endcase
    end

    // Bus monitor: completed reads/writes and request stability while waiting
    always @(negedge clk) begin
        if (mem_req && mem_ack && !mem_we && rd_n < 1024) begin
            rd_log[rd_n] = mem_addr;
            rd_n++;
        end
        if (mem_req && mem_ack && mem_we) begin
            st_n++;
            st_addr = mem_addr;
            st_data = mem_wdata;
        end
        if (pend && rst_n && (!mem_req || mem_addr !== p_addr || mem_we !== p_we ||
                              mem_wdata !== p_wd))
            stab_err++;
        pend   = rst_n && mem_req && !mem_ack;
        p_addr = mem_addr;
        p_we   = mem_we;
        p_wd   = mem_wdata;
    end

    function automatic logic [15:0] enc(input logic [4:0] op, input int f);
        return {op, 11'(f)};
    endfunction

    task automatic clear_mem;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    endtask

    task automatic run(input int hold, output int cyc, output int rd_base,
                       output int st_base, output int stab_base);
        @(negedge clk);
        #1;
        rd_base   = rd_n;
        st_base   = st_n;
        stab_base = stab_err;
        start     = 1'b1;
        cyc       = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        while (!halted && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic load_prog1;
        clear_mem();
        mem[0] = enc(c_LDI, 5);
        mem[1] = enc(c_ADDI, 3);
        mem[2] = enc(c_STORE, 20);
        mem[3] = enc(c_HALT, 0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, busy, halted} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: req/we/busy/halted=%b required 0000",
                     {mem_req, mem_we, busy, halted});
        end
        checks++;
        if (acc !== 16'h0 || pc !== 11'h0 || mem_addr !== 11'h0) begin
            errors++;
            $display("FAIL reset_regs: acc=%h pc=%h addr=%h required 0", acc, pc, mem_addr);
        end
        checks++;
        if (alu_a !== 16'h0 || alu_opcode !== 5'h0 || mem_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_alu: a=%h op=%h wdata=%h required 0", alu_a, alu_opcode, mem_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: busy=%b req=%b required 0 0", busy, mem_req);
        end
    endtask

    task automatic test_program;
        int cyc, rb, sb, tb;
        load_prog1();
        ack_wait = 0;
        run(1, cyc, rb, sb, tb);
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL prog_cycles: got %0d required 8", cyc);
        end
        checks++;
        if (acc !== 16'd8 || pc !== 11'd3 || halted !== 1'b1) begin
            errors++;
            $display("FAIL prog_state: acc=%h pc=%h halted=%b required 0008 003 1", acc, pc, halted);
        end
        checks++;
        if (st_n - sb !== 1 || st_addr !== 11'd20 || st_data !== 16'd8) begin
            errors++;
            $display("FAIL prog_store: n=%0d addr=%0d data=%h required 1 20 0008",
                     st_n - sb, st_addr, st_data);
        end
    endtask

    task automatic test_direct;
        int cyc, rb, sb, tb;
        clear_mem();
        mem[0]  = enc(c_LD, 30);
        mem[1]  = enc(c_ANDI, 16'h0FF);
        mem[2]  = enc(c_NOT, 0);
        mem[3]  = enc(c_HALT, 0);
        mem[30] = 16'h00F0;
        run(1, cyc, rb, sb, tb);
        checks++;
        if (acc !== 16'hFF0F) begin
            errors++;
            $display("FAIL direct_acc: got %h required ff0f", acc);
        end
        checks++;
        if (rd_n - rb !== 5 || rd_log[rb+1] !== 11'd30 || rd_log[rb+2] !== 11'd1) begin
            errors++;
            $display("FAIL direct_reads: n=%0d second=%0d third=%0d required 5 30 1",
                     rd_n - rb, rd_log[rb+1], rd_log[rb+2]);
        end
        checks++;
        if (cyc !== 9 || pc !== 11'd3) begin
            errors++;
            $display("FAIL direct_timing: cycles=%0d pc=%0d required 9 3", cyc, pc);
        end
    endtask

    task automatic test_wait_states;
        int cyc, rb, sb, tb;
        load_prog1();
        ack_wait = 3;
        run(3, cyc, rb, sb, tb);
        ack_wait = 0;
        checks++;
        if (acc !== 16'd8 || pc !== 11'd3 || halted !== 1'b1) begin
            errors++;
            $display("FAIL wait_state: acc=%h pc=%h halted=%b required 0008 003 1", acc, pc, halted);
        end
        checks++;
        if (st_n - sb !== 1 || st_addr !== 11'd20 || st_data !== 16'd8) begin
            errors++;
            $display("FAIL wait_store: n=%0d addr=%0d data=%h required 1 20 0008",
                     st_n - sb, st_addr, st_data);
        end
        checks++;
        if (stab_err - tb !== 0) begin
            errors++;
            $display("FAIL wait_stable: unstable request cycles=%0d required 0", stab_err - tb);
        end
        checks++;
        if (cyc !== 23) begin
            errors++;
            $display("FAIL wait_cycles: got %0d required 23", cyc);
        end
    endtask

    task automatic test_branch;
        int cyc, rb, sb, tb;
        clear_mem();
        mem[0]     = enc(c_JZ, 7);
        mem[1]     = enc(c_HALT, 0);
        mem[3]     = enc(c_LDI, 16'h55);
        mem[4]     = enc(c_HALT, 0);
        mem[7]     = enc(c_LDI, 1);
        mem[8]     = enc(c_JZ, 3);
        mem[9]     = enc(c_JMP, 11'h7FF);
        mem[11'h7FF] = enc(c_NOP, 0);
        run(1, cyc, rb, sb, tb);
        checks++;
        if (acc !== 16'd1 || pc !== 11'd1) begin
            errors++;
            $display("FAIL branch_final: acc=%h pc=%h required 0001 001", acc, pc);
        end
        checks++;
        if (rd_n - rb !== 7 || rd_log[rb+1] !== 11'd7 || rd_log[rb+3] !== 11'd9) begin
            errors++;
            $display("FAIL branch_jz: n=%0d second=%0d fourth=%0d required 7 7 9",
                     rd_n - rb, rd_log[rb+1], rd_log[rb+3]);
        end
        checks++;
        if (rd_log[rb+4] !== 11'h7FF || rd_log[rb+5] !== 11'd0) begin
            errors++;
            $display("FAIL branch_wrap: fifth=%h sixth=%h required 7ff 000",
                     rd_log[rb+4], rd_log[rb+5]);
        end
        checks++;
        if (cyc !== 14) begin
            errors++;
            $display("FAIL branch_cycles: got %0d required 14", cyc);
        end
    endtask

    task automatic test_shifts;
        int cyc, rb, sb, tb;
        clear_mem();
        mem[0] = enc(c_LDI, 1);
        mem[1] = enc(c_SHLI, 4);
        mem[2] = enc(c_HALT, 0);
        run(1, cyc, rb, sb, tb);
        checks++;
        if (acc !== 16'h0010) begin
            errors++;
            $display("FAIL shl: got %h required 0010", acc);
        end
        mem[2] = enc(c_SHRI, 4);
        mem[3] = enc(c_BAD, 16'h123);
        mem[4] = enc(c_HALT, 0);
        run(1, cyc, rb, sb, tb);
        checks++;
        if (acc !== 16'h0001 || pc !== 11'd4) begin
            errors++;
            $display("FAIL shr_unknown: acc=%h pc=%h required 0001 004", acc, pc);
        end
    endtask

    task automatic test_reset_mid;
        int cyc, rb, sb, tb, k;
        clear_mem();
        mem[0]  = enc(c_LDI, 5);
        mem[1]  = enc(c_LD, 30);
        mem[2]  = enc(c_ANDI, 16'h0FF);
        mem[3]  = enc(c_NOT, 0);
        mem[4]  = enc(c_HALT, 0);
        mem[30] = 16'h00F0;
        ack_wait = 3;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(mem_req && !mem_we && mem_addr == 11'd30) && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 100 || acc !== 16'd5 || pc !== 11'd1) begin
            errors++;
            $display("FAIL midrst_reach: waited=%0d acc=%h pc=%h required <100 0005 001", k, acc, pc);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, busy, halted} !== 4'b0000 || mem_addr !== 11'h0) begin
            errors++;
            $display("FAIL midrst_bus: req/we/busy/halted=%b addr=%h required 0000 000",
                     {mem_req, mem_we, busy, halted}, mem_addr);
        end
        checks++;
        if (acc !== 16'h0 || pc !== 11'h0 || alu_a !== 16'h0 || mem_wdata !== 16'h0) begin
            errors++;
            $display("FAIL midrst_regs: acc=%h pc=%h a=%h wdata=%h required 0",
                     acc, pc, alu_a, mem_wdata);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        ack_wait = 0;
        run(1, cyc, rb, sb, tb);
        checks++;
        if (acc !== 16'hFF0F || pc !== 11'd4 || halted !== 1'b1) begin
            errors++;
            $display("FAIL midrst_rerun: acc=%h pc=%h halted=%b required ff0f 004 1", acc, pc, halted);
        end
        checks++;
        if (rd_n - rb !== 6 || rd_log[rb] !== 11'd0 || rd_log[rb+2] !== 11'd30 || cyc !== 11) begin
            errors++;
            $display("FAIL midrst_trace: n=%0d first=%0d third=%0d cycles=%0d required 6 0 30 11",
                     rd_n - rb, rd_log[rb], rd_log[rb+2], cyc);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        ack_wait = 0;
        wait_cnt = 0;
        clear_mem();
        test_reset();
        test_program();
        test_direct();
        test_wait_states();
        test_branch();
        test_shifts();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
